// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, reset PC and the NOP word.
package ifetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    HALT = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/ifetch_unit_branch_compare.sv
// Branch condition evaluation: OR of every asserted branch flag whose comparison holds.
module branch_compare (
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Branch_lt,
  input  logic        Branch_ge,
  input  logic        Branch_ltu,
  input  logic        Branch_geu,
  output logic        taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  assign taken = (Branch     &  eq)   |
                 (nBranch    & ~eq)   |
                 (Branch_lt  &  lt_s) |
                 (Branch_ge  & ~lt_s) |
                 (Branch_ltu &  lt_u) |
                 (Branch_geu & ~lt_u);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register plus a request/wait/execute FSM towards instruction memory.
// A misaligned next PC halts fetch until reset.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Branch_lt,
  input  logic        Branch_ge,
  input  logic        Branch_ltu,
  input  logic        Branch_geu,
  input  logic        Jal,
  input  logic        Jr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] Addr_result,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic        misalign_err
);

  state_t      state;
  logic        taken;
  logic [31:0] next_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  branch_compare u_branch_compare (
    .rs1        (rs1_data),
    .rs2        (rs2_data),
    .Branch     (Branch),
    .nBranch    (nBranch),
    .Branch_lt  (Branch_lt),
    .Branch_ge  (Branch_ge),
    .Branch_ltu (Branch_ltu),
    .Branch_geu (Branch_geu),
    .taken      (taken)
  );

  // jalr clears bit 0 of its target before the alignment check
  always_comb begin
    next_pc = pc_plus4;
    if (Jr)
      next_pc = {jr_target[31:1], 1'b0};
    else if (Jal || taken)
      next_pc = Addr_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      Instruction  <= NOP;
      misalign_err <= 1'b0;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
    end else begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            Instruction <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (stall) begin
            instr_valid <= 1'b1;
          end else if (next_pc[1:0] != 2'b00) begin
            misalign_err <= 1'b1;
            state        <= HALT;
          end else begin
            pc       <= next_pc;
            imem_req <= 1'b1;
            state    <= REQ;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_req  output  1  one-cycle pulse requesting an instruction read at imem_addr.
REQ-005 imem_addr  output  32  byte address of the requested word (equals pc).
REQ-006 imem_rvalid  input  1  read data valid; arrives 1 or more cycles after imem_req.
REQ-007 imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-008 Instruction  output  32  registered instruction feeding the decode/control stage.
REQ-009 instr_valid  output  1  Instruction and pc are valid for decode/execute this cycle.
REQ-010 pc / pc_plus4  output  32 each  address of Instruction / pc+4 (jal/jalr link value).
REQ-011 Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu, Jal, Jr  input  1 each  control-stage decode of Instruction.
REQ-012 rs1_data, rs2_data  input  32 each  register operands for branch comparison.
REQ-013 Addr_result  input  32  branch/jal target (pc+imm).
REQ-014 jr_target  input  32  jalr target (rs1+imm), unmasked.
REQ-015 stall  input  1  holds the current instruction in execute.
REQ-016 misalign_err  output  1  sticky flag: misaligned target detected, fetch halted.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, EXEC, HALT; reset state IDLE.
REQ-018 IDLE SHALL go to REQ after one cycle.
REQ-019 REQ SHALL assert imem_req for exactly one cycle with imem_addr=pc, then go to WAIT.
REQ-020 WAIT SHALL hold until imem_rvalid=1, latch imem_rdata into Instruction, then go to EXEC; imem_rvalid outside WAIT SHALL be ignored.
REQ-021 instr_valid SHALL be 1 only in EXEC; fetch-to-execute latency is 2 cycles minimum (REQ, WAIT with immediate rvalid).
REQ-022 In EXEC with stall=1, the FSM SHALL remain in EXEC with pc and Instruction unchanged.
REQ-023 In EXEC with stall=0, pc SHALL load next_pc and the FSM SHALL go to REQ.
REQ-024 taken = Branch&(rs1==rs2) | nBranch&(rs1!=rs2) | Branch_lt&signed(rs1<rs2) | Branch_ge&signed(rs1>=rs2) | Branch_ltu&unsigned(rs1<rs2) | Branch_geu&unsigned(rs1>=rs2).
REQ-025 next_pc priority SHALL be: Jr -> {jr_target[31:1],1'b0}; else Jal -> Addr_result; else taken -> Addr_result; else pc_plus4.
REQ-026 pc_plus4 SHALL be 32-bit modulo; pc=32'hFFFF_FFFC gives 32'h0000_0000 with no error.
REQ-027 If next_pc[1:0]!=0 at the EXEC exit, pc SHALL be held, misalign_err SHALL set, and the FSM SHALL enter HALT.
REQ-028 HALT SHALL be left only by reset; imem_req=0 and instr_valid=0 in HALT.
REQ-029 Multiple branch flags asserted together SHALL be OR-combined per REQ-024 without error.

Reset
REQ-030 On rst: pc=RESET_PC, Instruction=32'h0000_0013 (nop), state=IDLE, misalign_err=0, imem_req=0, instr_valid=0, immediately and asynchronously.
REQ-031 rst asserted during WAIT SHALL abort the fetch; a late imem_rvalid after reset release SHALL be ignored (not in WAIT).

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, RESET_PC default, and the NOP constant.
REQ-033 One sub-module, branch_compare (rs1, rs2, six branch flags -> taken), is natural; PC register and FSM stay in ifetch_unit.

Verification
REQ-034 Reset, rvalid one cycle after each req, no branches -> pc sequence 0,4,8; instr_valid pulses every 3 cycles.
REQ-035 Branch_lt=1, rs1=32'hFFFF_FFFF, rs2=1, Addr_result=0x40 -> next pc=0x40; same with Branch_ltu -> pc+4.
REQ-036 Jr=1 and Jal=1 together, jr_target=0x101, Addr_result=0x80 -> pc=0x100.
REQ-037 Jal=1, Addr_result=0x42 -> misalign_err=1, HALT, no further imem_req until rst.
REQ-038 stall=1 for 5 EXEC cycles -> Instruction/pc stable, no imem_req; release -> pc advances once.
REQ-039 rst pulse during WAIT then rvalid the next cycle -> pc=RESET_PC, Instruction=nop, fresh fetch at RESET_PC.
